// File: rtl/tmr_regfile.sv
// -----------------------------------------------------------------------------
// tmr_regfile
//
// Triple-modular-redundant 32 x 32 register file with two voted read ports,
// one write port, a background scrubber that repairs disagreeing copies, and a
// fault-injection port.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-low reset (clears everything)
//   we3/wa3/wd3  write port; the write goes into all three copies, r0 ignored
//   ra1/ra2      read addresses; rd1/rd2 are combinational majority votes
//   scrub_en     lets the scrubber step through the registers
//   inj_en       fault-injection strobe: copy inj_copy of register inj_addr
//                is XORed with inj_mask (copy 3 or register 0 = no-op)
//   fault        one-cycle pulse after the scrubber repairs a register
//   fault_count  number of repairs, saturating at 16'hFFFF
//   scrub_ptr    register the scrubber is currently checking
// -----------------------------------------------------------------------------
module tmr_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic        we3,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa3,
   input  logic [31:0] wd3,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        scrub_en,
   input  logic        inj_en,
   input  logic [1:0]  inj_copy,
   input  logic [4:0]  inj_addr,
   input  logic [31:0] inj_mask,
   output logic        fault,
   output logic [15:0] fault_count,
   output logic [4:0]  scrub_ptr
);

   typedef enum logic {ST_CHECK = 1'b0, ST_FIX = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [4:0]  scrub_ptr_q, scrub_ptr_d;
   logic [4:0]  fix_addr_q, fix_addr_d;
   logic [31:0] fix_val_q, fix_val_d;
   logic        fault_q, fault_d;
   logic [15:0] fault_count_q, fault_count_d;

   logic [2:0][31:0] rd1_copy;
   logic [2:0][31:0] rd2_copy;
   logic [2:0][31:0] chk_copy;
   logic [31:0]      chk_vote;

   logic wr_en;
   logic inj_hit;
   logic mismatch;
   logic latch_en;
   logic advance;
   logic repair_we;

   function automatic logic [31:0] maj3(input logic [2:0][31:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   assign wr_en   = we3 && (wa3 != 5'd0);
   assign inj_hit = inj_en && (inj_addr != 5'd0);

   // ---------------------------------------------------------------------------
   // Three storage copies. Update order inside a copy: repair, then user write
   // (so a same-address user write overrides, though repair_we already drops
   // out in that case), then injection on top of whatever was just written.
   // Entry 0 is never written, so it stays at its reset value.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_copy
         logic [31:0] mem_q [32];
         logic [31:0] mem_d [32];

         always_comb begin
            mem_d = mem_q;
            if (repair_we) begin
               mem_d[fix_addr_q] = fix_val_q;
            end
            if (wr_en) begin
               mem_d[wa3] = wd3;
            end
            // inj_copy == 3 never matches any copy index, giving the no-op.
            if (inj_hit && (inj_copy == 2'(gi))) begin
               mem_d[inj_addr] = mem_d[inj_addr] ^ inj_mask;
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < 32; i++) begin
                  mem_q[i] <= '0;
               end
            end else begin
               mem_q <= mem_d;
            end
         end

         assign rd1_copy[gi] = mem_q[ra1];
         assign rd2_copy[gi] = mem_q[ra2];
         assign chk_copy[gi] = mem_q[scrub_ptr_q];
      end
   endgenerate

   assign rd1      = (ra1 == 5'd0) ? '0 : maj3(rd1_copy);
   assign rd2      = (ra2 == 5'd0) ? '0 : maj3(rd2_copy);
   assign chk_vote = maj3(chk_copy);
   assign mismatch = (chk_copy[0] != chk_copy[1]) || (chk_copy[1] != chk_copy[2]);

   // ---------------------------------------------------------------------------
   // Scrub FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_CHECK;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CHECK: if (scrub_en && mismatch) state_d = ST_FIX;
         ST_FIX:   state_d = ST_CHECK;   // FIX completes regardless of scrub_en
         default:  state_d = ST_CHECK;
      endcase
   end

   always_comb begin
      latch_en  = 1'b0;
      advance   = 1'b0;
      repair_we = 1'b0;
      case (state_q)
         ST_CHECK: begin
            latch_en = scrub_en && mismatch;
            advance  = scrub_en && !mismatch;
         end
         ST_FIX: begin
            advance   = 1'b1;
            // A user write to the register under repair supersedes the repair.
            repair_we = !(we3 && (wa3 == fix_addr_q));
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Scrub datapath and health counters
   // ---------------------------------------------------------------------------
   always_comb begin
      fix_addr_d    = latch_en ? scrub_ptr_q : fix_addr_q;
      fix_val_d     = latch_en ? chk_vote    : fix_val_q;
      scrub_ptr_d   = scrub_ptr_q;
      if (advance) begin
         // Register 0 holds nothing worth checking, so the sweep is 1..31.
         scrub_ptr_d = (scrub_ptr_q == 5'd31) ? 5'd1 : scrub_ptr_q + 5'd1;
      end
      fault_d       = repair_we;
      fault_count_d = fault_count_q;
      if (repair_we && (fault_count_q != 16'hFFFF)) begin
         fault_count_d = fault_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scrub_ptr_q   <= 5'd1;
         fix_addr_q    <= '0;
         fix_val_q     <= '0;
         fault_q       <= 1'b0;
         fault_count_q <= '0;
      end else begin
         scrub_ptr_q   <= scrub_ptr_d;
         fix_addr_q    <= fix_addr_d;
         fix_val_q     <= fix_val_d;
         fault_q       <= fault_d;
         fault_count_q <= fault_count_d;
      end
   end

   assign fault       = fault_q;
   assign fault_count = fault_count_q;
   assign scrub_ptr   = scrub_ptr_q;

endmodule

// File: tb/tb_tmr_regfile.sv
// -----------------------------------------------------------------------------
// tb_tmr_regfile
//
// Self-checking bench for tmr_regfile. The reference model keeps one golden
// value per register plus a per-copy corruption mask; a voted read is the
// golden value with every bit flipped that is corrupted in at least two copies.
// Expected reads are queued by the stimulus and compared by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_tmr_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        we3;
   logic [4:0]  ra1, ra2, wa3;
   logic [31:0] wd3;
   logic [31:0] rd1, rd2;
   logic        scrub_en;
   logic        inj_en;
   logic [1:0]  inj_copy;
   logic [4:0]  inj_addr;
   logic [31:0] inj_mask;
   logic        fault;
   logic [15:0] fault_count;
   logic [4:0]  scrub_ptr;

   always #5 clk = ~clk;

   tmr_regfile dut (
      .clk         (clk),
      .reset       (reset),
      .we3         (we3),
      .ra1         (ra1),
      .ra2         (ra2),
      .wa3         (wa3),
      .wd3         (wd3),
      .rd1         (rd1),
      .rd2         (rd2),
      .scrub_en    (scrub_en),
      .inj_en      (inj_en),
      .inj_copy    (inj_copy),
      .inj_addr    (inj_addr),
      .inj_mask    (inj_mask),
      .fault       (fault),
      .fault_count (fault_count),
      .scrub_ptr   (scrub_ptr)
   );

   typedef struct packed {
      logic [4:0]  a1;
      logic [31:0] r1;
      logic [4:0]  a2;
      logic [31:0] r2;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gold [32];
   logic [31:0] err  [3][32];
   int          checks = 0;
   int          errors = 0;
   int          fault_pulses = 0;
   int          exp_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic [31:0] v;
      int n;
      if (a == 5'd0) return 32'h0;
      v = gold[a];
      for (int b = 0; b < 32; b++) begin
         n = int'(err[0][a][b]) + int'(err[1][a][b]) + int'(err[2][a][b]);
         if (n >= 2) v[b] = ~v[b];
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         gold[r] = '0;
         for (int c = 0; c < 3; c++) err[c][r] = '0;
      end
      exp_count = 0;
   endtask

   task automatic clear_err(input int r);
      for (int c = 0; c < 3; c++) err[c][r] = '0;
   endtask

   // One clock of stimulus: random read addresses, queued expectation, edge,
   // then the model absorbs whatever write/injection was presented.
   task automatic cycle();
      exp_t e;
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      e.a1 = ra1; e.r1 = model_read(ra1);
      e.a2 = ra2; e.r2 = model_read(ra2);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (we3) $display("write r%0d = %h", wa3, wd3);
      if (inj_en) $display("inject copy%0d r%0d ^= %h", inj_copy, inj_addr, inj_mask);
      if (we3 && wa3 != 5'd0) begin
         gold[wa3] = wd3;
         clear_err(int'(wa3));
      end
      if (inj_en && inj_copy != 2'd3 && inj_addr != 5'd0) begin
         err[inj_copy][inj_addr] = err[inj_copy][inj_addr] ^ inj_mask;
      end
      we3    = 1'b0;
      inj_en = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      we3 = 1'b1; wa3 = a; wd3 = d;
      cycle();
   endtask

   task automatic do_inject(input logic [1:0] c, input logic [4:0] a, input logic [31:0] m);
      inj_en = 1'b1; inj_copy = c; inj_addr = a; inj_mask = m;
      cycle();
   endtask

   task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] req);
      ra1 = a;
      #1;
      check(name, rd1, req);
   endtask

   task automatic run_until_ptr(input logic [4:0] t, input int budget);
      int k = 0;
      while (scrub_ptr !== t && k < budget) begin
         cycle();
         k++;
      end
      check("ptr_reach", 32'(scrub_ptr), 32'(t));
   endtask

   // Read scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check($sformatf("rd1[r%0d]", e.a1), rd1, e.r1);
         check($sformatf("rd2[r%0d]", e.a2), rd2, e.r2);
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1 && fault === 1'b1) fault_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int first;
      int sel;

      reset = 1'b0; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
      scrub_en = 1'b0; inj_en = 1'b0; inj_copy = '0; inj_addr = '0; inj_mask = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_count", 32'(fault_count), 32'h0);
      check("reset_ptr",   32'(scrub_ptr), 32'd1);
      check("reset_fault", 32'(fault), 32'h0);
      reset = 1'b1;

      // Basic write / read, r0 hardwired
      do_write(5'd5, 32'hDEADBEEF);
      read_check("r5_read", 5'd5, 32'hDEADBEEF);
      do_write(5'd0, 32'h1234);
      read_check("r0_read", 5'd0, 32'h0);

      // Random writes and injections with the scrubber off: exercises voting
      // including multi-copy corruption.
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3) begin
            we3 = 1'b1; wa3 = 5'($urandom_range(0, 31)); wd3 = $urandom;
         end else if (sel < 6) begin
            inj_en = 1'b1; inj_copy = 2'($urandom_range(0, 3));
            inj_addr = 5'($urandom_range(0, 31));
            inj_mask = ($urandom_range(0, 1) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
         end
         cycle();
      end
      check("frozen_ptr",   32'(scrub_ptr), 32'd1);
      check("frozen_count", 32'(fault_count), 32'h0);
      check("frozen_pulses", 32'(fault_pulses), 32'h0);

      // Rewrite everything so every register is clean again.
      for (int r = 1; r < 32; r++) begin
         if (r == 3)      do_write(5'(r), 32'h0);
         else if (r == 5) do_write(5'(r), 32'hDEADBEEF);
         else if (r == 7) do_write(5'(r), 32'hA5A5A5A5);
         else             do_write(5'(r), $urandom);
      end

      // Single bad copy is masked; nothing happens while scrub_en=0.
      do_inject(2'd1, 5'd7, 32'hFFFFFFFF);
      read_check("r7_vote", 5'd7, 32'hA5A5A5A5);
      run(5);
      check("noscrub_count", 32'(fault_count), 32'h0);
      check("noscrub_ptr",   32'(scrub_ptr), 32'd1);

      // Enable scrubbing: ptr=1 -> reaches r7 after 6 steps, FIX next cycle,
      // fault visible after the following edge (7th returned cycle index).
      scrub_en = 1'b1;
      p0 = fault_pulses;
      first = -1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (fault === 1'b1 && first < 0) first = i;
      end
      check("fault_latency", 32'(first), 32'd7);
      check("r7_pulses", 32'(fault_pulses - p0), 32'd1);
      exp_count++;
      check("r7_count", 32'(fault_count), 32'(exp_count));
      clear_err(7);

      do_inject(2'd0, 5'd7, $urandom | 32'h1);
      p0 = fault_pulses;
      run(40);
      check("r7b_pulses", 32'(fault_pulses - p0), 32'd1);
      exp_count++;
      check("r7b_count", 32'(fault_count), 32'(exp_count));
      clear_err(7);
      read_check("r7_after", 5'd7, 32'hA5A5A5A5);

      // User write to the register being repaired wins.
      do_inject(2'd2, 5'd9, 32'h00FF0000);
      p0 = fault_pulses;
      run_until_ptr(5'd9, 40);
      cycle();
      check("fix_ptr_hold", 32'(scrub_ptr), 32'd9);
      we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h55;
      cycle();
      check("fix_ptr_adv", 32'(scrub_ptr), 32'd10);
      read_check("r9_user", 5'd9, 32'h55);
      run(40);
      check("r9_pulses", 32'(fault_pulses - p0), 32'd0);
      check("r9_count", 32'(fault_count), 32'(exp_count));

      // Two copies corrupted in disjoint bits: vote still 0, one repair.
      scrub_en = 1'b0;
      run(3);
      do_inject(2'd0, 5'd3, 32'h0F);
      do_inject(2'd2, 5'd3, 32'hF0);
      read_check("r3_vote", 5'd3, 32'h0);
      scrub_en = 1'b1;
      p0 = fault_pulses;
      run(40);
      check("r3_pulses", 32'(fault_pulses - p0), 32'd1);
      exp_count++;
      check("r3_count", 32'(fault_count), 32'(exp_count));
      clear_err(3);
      // Corrupting copy1 now only reads 0 if copies 0 and 2 were both restored.
      scrub_en = 1'b0;
      run(3);
      do_inject(2'd1, 5'd3, 32'hFF);
      read_check("r3_restored", 5'd3, 32'h0);
      scrub_en = 1'b1;
      p0 = fault_pulses;
      run(40);
      check("r3b_pulses", 32'(fault_pulses - p0), 32'd1);
      exp_count++;
      clear_err(3);

      // Saturation
      force dut.fault_count_q = 16'hFFFE;
      #1;
      release dut.fault_count_q;
      exp_count = 32'hFFFE;
      check("preload", 32'(fault_count), 32'hFFFE);
      do_inject(2'd2, 5'd11, 32'h8000_0001);
      p0 = fault_pulses;
      run(40);
      check("sat1_pulses", 32'(fault_pulses - p0), 32'd1);
      check("sat1_count", 32'(fault_count), 32'hFFFF);
      clear_err(11);
      do_inject(2'd1, 5'd11, 32'h0000_0100);
      p0 = fault_pulses;
      run(40);
      check("sat2_pulses", 32'(fault_pulses - p0), 32'd1);
      check("sat2_count", 32'(fault_count), 32'hFFFF);
      clear_err(11);

      // Reset in the middle of a FIX
      do_inject(2'd1, 5'd13, 32'h0000FFFF);
      run_until_ptr(5'd13, 40);
      cycle();
      check("midfix_hold", 32'(scrub_ptr), 32'd13);
      reset = 1'b0;
      ra2 = 5'd5;
      #1;
      check("rst_count", 32'(fault_count), 32'h0);
      check("rst_ptr",   32'(scrub_ptr), 32'd1);
      check("rst_fault", 32'(fault), 32'h0);
      read_check("rst_r13", 5'd13, 32'h0);
      check("rst_r5", rd2, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();

      // Clean sweep: 31 steps, wraps 31 -> 1
      p0 = fault_pulses;
      run(30);
      check("sweep_31", 32'(scrub_ptr), 32'd31);
      run(1);
      check("sweep_wrap", 32'(scrub_ptr), 32'd1);
      run(35);
      check("clean_pulses", 32'(fault_pulses - p0), 32'd0);
      check("clean_count", 32'(fault_count), 32'h0);

      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmr_regfile.md
# tmr_regfile

Triple-modular-redundant replacement for the MIPS three-ported register file, sitting directly upstream of the ALU and feeding its a/b operands. It holds three copies of every register, returns bitwise-majority-voted reads, and runs a background scrub state machine that finds and repairs disagreeing copies. A fault-injection port and a saturating fault counter support verification and health monitoring.

## Interface
- No parameters: 32 registers × 32 bits, 3 copies, fixed.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- we3  in  1  write enable for port 3
- ra1, ra2  in  5  read addresses
- wa3  in  5  write address
- wd3  in  32  write data
- rd1, rd2  out  32  voted read data
- scrub_en  in  1  enables the background scrubber
- inj_en  in  1  fault-injection strobe
- inj_copy  in  2  copy to corrupt (0..2; 3 = no-op)
- inj_addr  in  5  register to corrupt (0 = no-op)
- inj_mask  in  32  bits XORed into the selected copy
- fault  out  1  one-cycle pulse when the scrubber repairs a register
- fault_count  out  16  number of repairs, saturating at 16'hFFFF
- scrub_ptr  out  5  register currently being checked (debug)

## Operation
- Storage: copies c0, c1, c2, each 32×32. Register 0 is never written and always reads 0.
- Read: rdN = (ra==0) ? 0 : maj(c0[ra], c1[ra], c2[ra]); bitwise majority (a&b)|(a&c)|(b&c). Purely combinational.
- Write: on a clock edge with we3=1 and wa3≠0, wd3 goes into all three copies.
- Injection: on a clock edge with inj_en=1, inj_copy≤2, and inj_addr≠0, c[inj_copy][inj_addr] ^= inj_mask. Injection is applied after any same-edge write or repair, so the result is (new value) ^ mask.
- Scrub FSM, states CHECK and FIX:
  - CHECK, scrub_en=1: compare the three copies at scrub_ptr.
    - Match: scrub_ptr advances. Wraps 31→1 and never visits 0.
    - Mismatch: latch the voted value and the address, go to FIX. scrub_ptr holds.
  - CHECK, scrub_en=0: stay in CHECK, scrub_ptr frozen.
  - FIX: write the latched voted value to all three copies, pulse fault, increment fault_count (saturating), advance scrub_ptr, return to CHECK. FIX always completes, even if scrub_en drops.
  - FIX with we3=1 and wa3 equal to the latched address: the user write wins. No repair write, no fault pulse, no count increment. scrub_ptr still advances.
  - FIX with we3 to a different address: both writes happen on the same edge.
- Reset: all copies cleared to 0, state=CHECK, scrub_ptr=1, fault=0, fault_count=0.

## Timing
- Read latency is 0 cycles. A write at edge k is visible on rd at edge k, after clock-to-q; there is no write-through bypass within the cycle.
- Clean sweep takes 31 cycles. Each repaired register adds 1 cycle.
- Latency from an injection at edge k into a register that scrub_ptr reaches in CHECK at cycle j>k:
  - Repair at edge j+1.
  - fault is high for the cycle after edge j+1.
- A mismatch is never visible on rd while only one copy is bad.
- Reset asserted mid-FIX aborts the repair; the no-count, all-zero reset state takes precedence immediately.
- fault_count at 16'hFFFF stays 16'hFFFF, and fault still pulses.

## Test plan
- Reset, then write 0xDEADBEEF to r5 → rd1 with ra1=5 reads 0xDEADBEEF the cycle after. Write r0=0x1234 → ra=0 reads 0.
- With scrub_en=0, inject mask 0xFFFFFFFF into copy 1 at r7 (r7 holds 0xA5A5A5A5) → rd reads 0xA5A5A5A5, fault_count stays 0, scrub_ptr frozen.
- Same injection, then scrub_en=1 → within 32 cycles fault pulses exactly once, fault_count=1. Re-inject into copy 0 only → r7 repaired again, count=2.
- Inject into r9. When scrub_ptr=9 and FSM is in FIX, drive we3=1, wa3=9, wd3=0x55 → r9 reads 0x55, no fault pulse, count unchanged.
- Inject mask 0x0F into copy 0 and mask 0xF0 into copy 2 at r3 (value 0) → rd reads 0, scrub restores all copies to 0, one fault pulse.
- Preload fault_count to 0xFFFE by repeated inject/repair cycles (or force), then two more repairs → saturates at 0xFFFF. Assert reset mid-FIX → count=0, scrub_ptr=1, all reads 0.
